// File: rtl/fifo_arb.sv
// ============================================================================
// Module   : fifo_arb
// Purpose  : Two-producer burst-fair write arbiter with a single consumer read
//            path onto a registered-output FIFO. Macro FIFO_ARB_STAT_EN
//            enables the full-stall cycle counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_arb #(
  parameter int BURST = 4
) (
  input  logic        ck,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [7:0]  din0,
  input  logic [7:0]  din1,
  output logic        ack0,
  output logic        ack1,
  output logic [7:0]  fifo_din,
  output logic        fifo_wen,
  input  logic        Ffull,
  input  logic        rd_req,
  output logic        fifo_ren,
  input  logic        Fempty,
  output logic        rd_valid,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_t;

  localparam logic [3:0] c_burst = 4'(BURST);

  owner_t     r_owner;
  logic       r_rr;
  logic [3:0] r_cnt;
  logic       r_rd_valid;

  logic       w_sel;
  logic       w_sel_id;
  logic       w_burst_left;
  owner_t     w_sel_owner;

  assign w_burst_left = (r_cnt < c_burst);

  // The current owner keeps the grant until its burst is spent, unless the
  // other side is idle; otherwise fall back to the round-robin preference.
  always_comb begin
    w_sel    = 1'b0;
    w_sel_id = 1'b0;
    if (r_owner == OWN0 && req0 && (w_burst_left || !req1)) begin
      w_sel    = 1'b1;
      w_sel_id = 1'b0;
    end else if (r_owner == OWN1 && req1 && (w_burst_left || !req0)) begin
      w_sel    = 1'b1;
      w_sel_id = 1'b1;
    end else if (r_rr ? req1 : req0) begin
      w_sel    = 1'b1;
      w_sel_id = r_rr;
    end else if (r_rr ? req0 : req1) begin
      w_sel    = 1'b1;
      w_sel_id = ~r_rr;
    end
    if (!rst) begin
      w_sel = 1'b0;
    end
  end

  assign w_sel_owner = w_sel_id ? OWN1 : OWN0;
  assign fifo_wen    = w_sel & ~Ffull;
  assign fifo_din    = !w_sel ? 8'h00 : (w_sel_id ? din1 : din0);
  assign ack0        = fifo_wen & ~w_sel_id;
  assign ack1        = fifo_wen &  w_sel_id;
  assign fifo_ren    = rst & rd_req & ~Fempty;
  assign rd_valid    = r_rd_valid;

  // A blocked write (FIFO full) leaves owner, rr and cnt untouched so the
  // pending request is served intact once space frees up.
  always_ff @(posedge ck) begin
    if (!rst) begin
      r_owner    <= IDLE;
      r_rr       <= 1'b0;
      r_cnt      <= 4'd0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= fifo_ren;
      if (fifo_wen) begin
        r_owner <= w_sel_owner;
        r_rr    <= ~w_sel_id;
        if (r_owner == w_sel_owner && w_burst_left) begin
          r_cnt <= r_cnt + 4'd1;
        end else begin
          r_cnt <= 4'd1;
        end
      end else if (!req0 && !req1) begin
        r_owner <= IDLE;
        r_cnt   <= 4'd0;
      end
    end
  end

`ifdef FIFO_ARB_STAT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge ck) begin
    if (!rst) begin
      r_stall_cnt <= 16'h0000;
    end else if ((req0 || req1) && Ffull && r_stall_cnt != 16'hFFFF) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

`default_nettype wire
